// File: rtl/mod6_pkg.sv
// Shared types and helpers for the mod-6 sequence checker: FSM states,
// the largest legal count value and the expected-successor function.
package mod6_pkg;

  localparam int unsigned Q_W = 3;
  localparam int unsigned CNT_W = 4;
  localparam logic [Q_W-1:0] MOD6_MAX = 3'd5;

  typedef enum logic [1:0] {
    HUNT,
    SYNC,
    LOCKED
  } state_t;

  // Next value a healthy mod-6 counter produces after v.
  function automatic logic [Q_W-1:0] mod6_succ(input logic [Q_W-1:0] v);
    return (v == MOD6_MAX) ? Q_W'(0) : v + Q_W'(1);
  endfunction

  function automatic logic mod6_legal(input logic [Q_W-1:0] v);
    return v <= MOD6_MAX;
  endfunction

endpackage

// File: rtl/mod6_sequence_checker_if.sv
// Sample stream and status bundle of the mod-6 sequence checker.
interface mod6_sequence_checker_if #(
  parameter int unsigned ERR_W = 8
);
  import mod6_pkg::*;

  logic             valid;
  logic [Q_W-1:0]   q_in;
  logic             clr_err;
  logic             locked;
  logic             err_pulse;
  logic             wrap_pulse;
  logic [ERR_W-1:0] err_count;

  modport master (
    output valid, q_in, clr_err,
    input  locked, err_pulse, wrap_pulse, err_count
  );

  modport slave (
    input  valid, q_in, clr_err,
    output locked, err_pulse, wrap_pulse, err_count
  );

endinterface

// File: rtl/sat_err_counter.sv
// Saturating event counter; a clear coinciding with an event leaves a count of one.
module sat_err_counter #(
  parameter int unsigned ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [ERR_W-1:0] count
);

  localparam logic [ERR_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? ERR_W'(1) : '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + ERR_W'(1);
    end
  end

endmodule

// File: rtl/mod6_sequence_checker.sv
// Watches a sampled mod-6 count, locks after LOCK_CNT consecutive successors,
// and flags sequence/legality errors and observed 5->0 wraps.
module mod6_sequence_checker
  import mod6_pkg::*;
#(
  parameter int unsigned LOCK_CNT = 3,
  parameter int unsigned ERR_W    = 8
) (
  input logic                   clk,
  input logic                   rst,
  mod6_sequence_checker_if.slave bus
);

  state_t             state, state_nx;
  logic [Q_W-1:0]     prev, prev_nx;
  logic [CNT_W-1:0]   match_cnt, match_nx;
  logic               err_c, wrap_c;
  logic               locked, err_pulse, wrap_pulse;
  logic [ERR_W-1:0]   err_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= HUNT;
      prev       <= '0;
      match_cnt  <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      state      <= state_nx;
      prev       <= prev_nx;
      match_cnt  <= match_nx;
      locked     <= (state_nx == LOCKED);
      err_pulse  <= err_c;
      wrap_pulse <= wrap_c;
    end
  end

  // Next state: only accepted samples move anything; illegal values always fall back to HUNT.
  always_comb begin
    state_nx = state;
    prev_nx  = prev;
    match_nx = match_cnt;
    err_c    = 1'b0;
    wrap_c   = 1'b0;
    if (bus.valid) begin
      if (!mod6_legal(bus.q_in)) begin
        state_nx = HUNT;
        match_nx = '0;
        err_c    = 1'b1;
      end else begin
        prev_nx = bus.q_in;
        case (state)
          HUNT: begin
            state_nx = SYNC;
            match_nx = CNT_W'(1);
          end
          SYNC: begin
            if (bus.q_in == mod6_succ(prev)) begin
              match_nx = match_cnt + CNT_W'(1);
              if (match_nx == CNT_W'(LOCK_CNT)) state_nx = LOCKED;
            end else begin
              match_nx = CNT_W'(1);
            end
          end
          LOCKED: begin
            if (bus.q_in == mod6_succ(prev)) begin
              wrap_c = (prev == MOD6_MAX);
            end else begin
              err_c    = 1'b1;
              state_nx = SYNC;
              match_nx = CNT_W'(1);
            end
          end
          default: begin
            state_nx = HUNT;
            match_nx = '0;
          end
        endcase
      end
    end
  end

  sat_err_counter #(.ERR_W(ERR_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_c),
    .clr   (bus.clr_err),
    .count (err_count)
  );

  assign bus.locked     = locked;
  assign bus.err_pulse  = err_pulse;
  assign bus.wrap_pulse = wrap_pulse;
  assign bus.err_count  = err_count;

endmodule

// File: tb/tb_mod6_sequence_checker.sv
// Bench for mod6_sequence_checker: directed vector table, reset/saturation sequences
// and random samples against a run-length reference model; two parameterisations.
module tb_mod6_sequence_checker;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mod6_sequence_checker_if #(.ERR_W(8)) bus_a ();
  mod6_sequence_checker_if #(.ERR_W(2)) bus_b ();

  mod6_sequence_checker #(.LOCK_CNT(3), .ERR_W(8)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  mod6_sequence_checker #(.LOCK_CNT(4), .ERR_W(2)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: length of the current successor chain decides lock.
  int lock_cnt[2] = '{3, 4};
  int cnt_max[2]  = '{255, 3};
  bit m_locked[2];
  bit m_err[2];
  bit m_wrap[2];
  int m_run[2];
  int m_last[2];
  int m_cnt[2];

  typedef struct {
    bit v; int q; bit c;
    bit l; bit e; bit w; int cnt;
  } vec_t;
  vec_t tbl[24];

  function automatic vec_t mk(bit v, int q, bit c, bit l, bit e, bit w, int cnt);
    vec_t r;
    r.v = v; r.q = q; r.c = c; r.l = l; r.e = e; r.w = w; r.cnt = cnt;
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_locked[i] = 1'b0; m_err[i] = 1'b0; m_wrap[i] = 1'b0;
      m_run[i] = 0; m_last[i] = 0; m_cnt[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input bit v, input int q, input bit c);
    m_err[i]  = 1'b0;
    m_wrap[i] = 1'b0;
    if (v) begin
      if (q > 5) begin
        m_err[i] = 1'b1; m_run[i] = 0; m_locked[i] = 1'b0;
      end else if (m_run[i] > 0 && q == (m_last[i] + 1) % 6) begin
        if (m_locked[i]) m_wrap[i] = (q == 0);
        m_run[i]++;
        if (m_run[i] >= lock_cnt[i]) m_locked[i] = 1'b1;
      end else begin
        m_err[i] = m_locked[i]; m_locked[i] = 1'b0; m_run[i] = 1;
      end
      if (q <= 5) m_last[i] = q;
    end
    if (c) m_cnt[i] = m_err[i] ? 1 : 0;
    else if (m_err[i] && m_cnt[i] < cnt_max[i]) m_cnt[i]++;
  endtask

  task automatic drive(input bit v, input int q, input bit c);
    bus_a.valid = v; bus_a.q_in = 3'(q); bus_a.clr_err = c;
    bus_b.valid = v; bus_b.q_in = 3'(q); bus_b.clr_err = c;
  endtask

  task automatic compare_model(input string tag);
    check($sformatf("%s a.locked", tag), int'(bus_a.locked), int'(m_locked[0]));
    check($sformatf("%s a.err_pulse", tag), int'(bus_a.err_pulse), int'(m_err[0]));
    check($sformatf("%s a.wrap_pulse", tag), int'(bus_a.wrap_pulse), int'(m_wrap[0]));
    check($sformatf("%s a.err_count", tag), int'(bus_a.err_count), m_cnt[0]);
    check($sformatf("%s b.locked", tag), int'(bus_b.locked), int'(m_locked[1]));
    check($sformatf("%s b.err_pulse", tag), int'(bus_b.err_pulse), int'(m_err[1]));
    check($sformatf("%s b.wrap_pulse", tag), int'(bus_b.wrap_pulse), int'(m_wrap[1]));
    check($sformatf("%s b.err_count", tag), int'(bus_b.err_count), m_cnt[1]);
  endtask

  // Apply one sample across an edge, update the model and compare just after the edge.
  task automatic step(input bit v, input int q, input bit c, input string tag);
    drive(v, q, c);
    @(posedge clk);
    model_step(0, v, q, c);
    model_step(1, v, q, c);
    #1;
    compare_model(tag);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 0, 1'b0);
    model_reset();
    #12;
    compare_model("reset");
    @(negedge clk);
    rst = 1'b0;

    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 1, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 2, 0, 1, 0, 0, 0);
    tbl[3]  = mk(1, 3, 0, 1, 0, 0, 0);
    tbl[4]  = mk(1, 4, 0, 1, 0, 0, 0);
    tbl[5]  = mk(1, 5, 0, 1, 0, 0, 0);
    tbl[6]  = mk(1, 0, 0, 1, 0, 1, 0);
    tbl[7]  = mk(1, 1, 0, 1, 0, 0, 0);
    tbl[8]  = mk(1, 2, 0, 1, 0, 0, 0);
    tbl[9]  = mk(1, 4, 0, 0, 1, 0, 1);
    tbl[10] = mk(1, 5, 0, 0, 0, 0, 1);
    tbl[11] = mk(1, 0, 0, 1, 0, 0, 1);
    tbl[12] = mk(0, 7, 0, 1, 0, 0, 1);
    tbl[13] = mk(1, 7, 0, 0, 1, 0, 2);
    tbl[14] = mk(1, 7, 0, 0, 1, 0, 3);
    tbl[15] = mk(1, 3, 0, 0, 0, 0, 3);
    tbl[16] = mk(1, 6, 0, 0, 1, 0, 4);
    tbl[17] = mk(1, 2, 0, 0, 0, 0, 4);
    tbl[18] = mk(0, 3, 0, 0, 0, 0, 4);
    tbl[19] = mk(1, 3, 0, 0, 0, 0, 4);
    tbl[20] = mk(1, 4, 1, 1, 0, 0, 0);
    tbl[21] = mk(1, 0, 1, 0, 1, 0, 1);
    tbl[22] = mk(1, 1, 0, 0, 0, 0, 1);
    tbl[23] = mk(0, 5, 0, 0, 0, 0, 1);

    for (int i = 0; i < 24; i++) begin
      step(tbl[i].v, tbl[i].q, tbl[i].c, $sformatf("vec%0d", i));
      check($sformatf("vec%0d locked", i), int'(bus_a.locked), int'(tbl[i].l));
      check($sformatf("vec%0d err_pulse", i), int'(bus_a.err_pulse), int'(tbl[i].e));
      check($sformatf("vec%0d wrap_pulse", i), int'(bus_a.wrap_pulse), int'(tbl[i].w));
      check($sformatf("vec%0d err_count", i), int'(bus_a.err_count), tbl[i].cnt);
    end

    // Asynchronous reset while both instances are locked.
    step(1'b1, 2, 1'b0, "prelock2");
    step(1'b1, 3, 1'b0, "prelock3");
    check("prelock a.locked", int'(bus_a.locked), 1);
    check("prelock b.locked", int'(bus_b.locked), 1);
    #2;
    rst = 1'b1;
    #1;
    check("async rst a.locked", int'(bus_a.locked), 0);
    check("async rst a.err_count", int'(bus_a.err_count), 0);
    check("async rst b.locked", int'(bus_b.locked), 0);
    check("async rst b.err_count", int'(bus_b.err_count), 0);
    model_reset();
    drive(1'b1, 4, 1'b0);
    @(posedge clk);
    #1;
    check("held rst a.locked", int'(bus_a.locked), 0);
    check("held rst a.err_pulse", int'(bus_a.err_pulse), 0);
    rst = 1'b0;
    step(1'b1, 4, 1'b0, "relock4");
    step(1'b1, 5, 1'b0, "relock5");
    check("relock after 2 a.locked", int'(bus_a.locked), 0);
    step(1'b1, 0, 1'b0, "relock0");
    check("relock after 3 a.locked", int'(bus_a.locked), 1);
    check("relock no wrap", int'(bus_a.wrap_pulse), 0);

    // Saturation of the narrow counter, then clear coinciding with an error.
    for (int i = 0; i < 5; i++) step(1'b1, 7, 1'b0, $sformatf("sat%0d", i));
    check("sat b.err_count", int'(bus_b.err_count), 3);
    check("sat a.err_count", int'(bus_a.err_count), 5);
    step(1'b1, 7, 1'b1, "clr+err");
    check("clr+err b.err_count", int'(bus_b.err_count), 1);
    step(1'b0, 7, 1'b1, "clr only");
    check("clr only b.err_count", int'(bus_b.err_count), 0);

    for (int i = 0; i < 400; i++) begin
      bit v, c;
      int q;
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 19) == 0);
      q = ($urandom_range(0, 9) < 7) ? (m_last[0] + 1) % 6 : int'($urandom_range(0, 7));
      step(v, q, c, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
